// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM states, R/W bit values, counter width.
// Glitch filter build option: I2C_GLITCH_FILTER_EN (used by i2c_target_fifo).
package i2c_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_RX_BYTE,
      S_RX_ACK,
      S_TX_BYTE,
      S_TX_ACK,
      S_WAIT_STOP
   } i2c_state_e;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   localparam int I2C_CNT_W = 4;

   function automatic logic maj3(
      input logic a,
      input logic b,
      input logic c
   );
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with valid/ready on both sides.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level;
   logic             push;
   logic             pop;

   assign wr_ready = (level != (AW+1)'(DEPTH));
   assign rd_valid = (level != '0);
   assign rd_data  = mem[rd_ptr];
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

endmodule

// File: rtl/i2c_target_fifo.sv
// Non-stretching I2C target with programmable address and RX/TX byte FIFOs.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
module i2c_target_fifo
   import i2c_pkg::*;
#(
   parameter int         RX_DEPTH  = 4,
   parameter int         TX_DEPTH  = 4,
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [6:0] own_addr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       rx_overflow,
   output logic       tx_underflow
);

   logic [1:0] scl_sy, sda_sy;
   logic       scl, sda, scl_q, sda_q;
   logic       scl_rise, scl_fall, start_c, stop_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_sy <= 2'b11;
         sda_sy <= 2'b11;
      end else begin
         scl_sy <= {scl_sy[0], scl_in};
         sda_sy <= {sda_sy[0], sda_in};
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_h, sda_h;
   logic       scl_f, sda_f;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_h <= 2'b11;
         sda_h <= 2'b11;
         scl_f <= 1'b1;
         sda_f <= 1'b1;
      end else begin
         scl_h <= {scl_h[0], scl_sy[1]};
         sda_h <= {sda_h[0], sda_sy[1]};
         scl_f <= maj3(scl_sy[1], scl_h[0], scl_h[1]);
         sda_f <= maj3(sda_sy[1], sda_h[0], sda_h[1]);
      end
   end

   assign scl = scl_f;
   assign sda = sda_f;
`else
   assign scl = scl_sy[1];
   assign sda = sda_sy[1];
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl;
         sda_q <= sda;
      end
   end

   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;
   assign start_c  = scl & scl_q & sda_q & ~sda;
   assign stop_c   = scl & scl_q & ~sda_q & sda;

   i2c_state_e           state, state_n;
   logic [7:0]           sh, sh_n;
   logic [I2C_CNT_W-1:0] cnt, cnt_n;
   logic [6:0]           addr_q, addr_n;
   logic                 rw, rw_n;
   logic                 oe_n, busy_n, ovf_n, und_n;
   logic                 rx_push, rx_wr_ready, tx_pop;
   logic [7:0]           tx_head, tx_byte;
   logic                 tx_head_valid, cnt_full;

   assign cnt_full = (cnt == I2C_CNT_W'(8));
   assign tx_byte  = tx_head_valid ? tx_head : IDLE_BYTE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         sh           <= '0;
         cnt          <= '0;
         addr_q       <= '0;
         rw           <= I2C_RW_WRITE;
         sda_oe       <= 1'b0;
         busy         <= 1'b0;
         rx_overflow  <= 1'b0;
         tx_underflow <= 1'b0;
      end else begin
         state        <= state_n;
         sh           <= sh_n;
         cnt          <= cnt_n;
         addr_q       <= addr_n;
         rw           <= rw_n;
         sda_oe       <= oe_n;
         busy         <= busy_n;
         rx_overflow  <= ovf_n;
         tx_underflow <= und_n;
      end
   end

   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      addr_n  = addr_q;
      rw_n    = rw;
      oe_n    = sda_oe;
      busy_n  = busy;
      ovf_n   = 1'b0;
      und_n   = 1'b0;
      rx_push = 1'b0;
      tx_pop  = 1'b0;
      if (stop_c) begin
         state_n = S_IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start_c) begin
         state_n = S_ADDR;
         cnt_n   = '0;
         oe_n    = 1'b0;
         addr_n  = own_addr;
      end else begin
         unique case (state)
            S_ADDR: begin
               if (scl_rise) begin
                  sh_n  = {sh[6:0], sda};
                  cnt_n = cnt + 1'b1;
               end else if (scl_fall && cnt_full) begin
                  if (sh[7:1] == addr_q) begin
                     state_n = S_ADDR_ACK;
                     oe_n    = 1'b1;
                     busy_n  = 1'b1;
                     rw_n    = sh[0];
                  end else begin
                     state_n = S_WAIT_STOP;
                     busy_n  = 1'b0;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_n = '0;
                  if (rw == I2C_RW_READ) begin
                     tx_pop  = 1'b1;
                     und_n   = ~tx_head_valid;
                     sh_n    = tx_byte;
                     oe_n    = ~tx_byte[7];
                     cnt_n   = I2C_CNT_W'(1);
                     state_n = S_TX_BYTE;
                  end else begin
                     oe_n    = 1'b0;
                     state_n = S_RX_BYTE;
                  end
               end
            end
            S_RX_BYTE: begin
               if (scl_rise) begin
                  sh_n  = {sh[6:0], sda};
                  cnt_n = cnt + 1'b1;
               end else if (scl_fall && cnt_full) begin
                  if (rx_wr_ready) begin
                     rx_push = 1'b1;
                     oe_n    = 1'b1;
                     state_n = S_RX_ACK;
                  end else begin
                     ovf_n   = 1'b1;
                     oe_n    = 1'b0;
                     state_n = S_WAIT_STOP;
                  end
               end
            end
            S_RX_ACK: begin
               if (scl_fall) begin
                  oe_n    = 1'b0;
                  cnt_n   = '0;
                  state_n = S_RX_BYTE;
               end
            end
            // cnt counts bits already placed on SDA
            S_TX_BYTE: begin
               if (scl_fall) begin
                  if (cnt_full) begin
                     oe_n    = 1'b0;
                     state_n = S_TX_ACK;
                  end else begin
                     oe_n  = ~sh[~cnt[2:0]];
                     cnt_n = cnt + 1'b1;
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise) begin
                  if (!sda) begin
                     tx_pop  = 1'b1;
                     und_n   = ~tx_head_valid;
                     sh_n    = tx_byte;
                     cnt_n   = '0;
                     state_n = S_TX_BYTE;
                  end else begin
                     state_n = S_WAIT_STOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (RX_DEPTH)
   ) u_rx (
      .clock    (clock),
      .reset    (reset),
      .wr_data  (sh),
      .wr_valid (rx_push),
      .wr_ready (rx_wr_ready),
      .rd_data  (rx_data),
      .rd_valid (rx_valid),
      .rd_ready (rx_ready)
   );

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx (
      .clock    (clock),
      .reset    (reset),
      .wr_data  (tx_data),
      .wr_valid (tx_valid),
      .wr_ready (tx_ready),
      .rd_data  (tx_head),
      .rd_valid (tx_head_valid),
      .rd_ready (tx_pop)
   );

endmodule

// File: tb/tb_i2c_target_fifo.sv
// Scoreboard bench for i2c_target_fifo: bit-banged master, queue-based
// reference model of both FIFOs, monitor comparing bus events and RX pops.
module tb_i2c_target_fifo;

   localparam int         RXD = 4;
   localparam int         TXD = 4;
   localparam int         Q   = 10;
   localparam logic [6:0] OWN = 7'h49;

   logic       clock = 1'b0;
   logic       reset;
   logic       scl_m, sda_m;
   logic       scl_in, sda_in, sda_oe;
   logic [6:0] own_addr;
   logic [7:0] rx_data, tx_data;
   logic       rx_valid, rx_ready, tx_valid, tx_ready;
   logic       busy, rx_overflow, tx_underflow;

   always #5 clock = ~clock;

   assign scl_in   = scl_m;
   assign sda_in   = sda_m & ~sda_oe;
   assign own_addr = OWN;

   i2c_target_fifo #(
      .RX_DEPTH  (RXD),
      .TX_DEPTH  (TXD),
      .IDLE_BYTE (8'hFF)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .scl_in       (scl_in),
      .sda_in       (sda_in),
      .sda_oe       (sda_oe),
      .own_addr     (own_addr),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .rx_overflow  (rx_overflow),
      .tx_underflow (tx_underflow)
   );

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] model_tx[$];
   logic [8:0] exp_bus[$];
   logic [8:0] obs_bus[$];
   int         ovf_seen = 0, und_seen = 0;
   int         exp_ovf = 0, exp_und = 0;
   int         oe_cycles = 0;
   logic       count_oe = 1'b0;
   logic [7:0] wbuf[8];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rx_unexpected: got %0h, required none", rx_data);
            end else begin
               check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
         end
         if (rx_overflow) ovf_seen++;
         if (tx_underflow) und_seen++;
         if (count_oe && sda_oe) oe_cycles++;
         while (obs_bus.size() > 0 && exp_bus.size() > 0)
            check("bus_event", 32'(obs_bus.pop_front()),
                  32'(exp_bus.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic bit_w(input logic b);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic bit_r(output logic b);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q / 2);
      b = sda_in;   tick(Q - Q / 2);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) bit_w(d[i]);
      bit_r(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic t;
      for (int i = 7; i >= 0; i--) begin
         bit_r(t);
         d[i] = t;
      end
      bit_w(nack);
   endtask

   task automatic chk_pulses();
      check("ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
      check("und_pulses", 32'(und_seen), 32'(exp_und));
   endtask

   task automatic tx_push(input logic [7:0] d);
      check("tx_ready", 32'(tx_ready), 32'(model_tx.size() < TXD));
      if (tx_ready) begin
         tx_data  = d;
         tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
         model_tx.push_back(d);
      end
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      tick(8);
      check("rx_drained", 32'(exp_rx.size()), 32'd0);
      check("rx_valid_empty", 32'(rx_valid), 32'd0);
   endtask

   task automatic do_write(input logic [6:0] a, input int n,
                           input bit stop_after);
      logic ack, full, match;
      match = (a == OWN);
      i2c_start();
      exp_bus.push_back({1'b0, 7'd0, ~match});
      write_byte({a, 1'b0}, ack);
      obs_bus.push_back({1'b0, 7'd0, ack});
      check("busy_addr_w", 32'(busy), 32'(match));
      for (int k = 0; k < n; k++) begin
         full = (exp_rx.size() >= RXD);
         if (match && !full) exp_rx.push_back(wbuf[k]);
         exp_bus.push_back({1'b0, 7'd0, ~match | full});
         write_byte(wbuf[k], ack);
         obs_bus.push_back({1'b0, 7'd0, ack});
         if (match && full) begin
            exp_ovf++;
            break;
         end
      end
      if (stop_after) begin
         i2c_stop();
         check("busy_stop_w", 32'(busy), 32'd0);
         chk_pulses();
      end
   endtask

   task automatic do_read(input logic [6:0] a, input int n);
      logic       ack, match;
      logic [7:0] d, e;
      match = (a == OWN);
      i2c_start();
      exp_bus.push_back({1'b0, 7'd0, ~match});
      write_byte({a, 1'b1}, ack);
      obs_bus.push_back({1'b0, 7'd0, ack});
      check("busy_addr_r", 32'(busy), 32'(match));
      if (match) begin
         for (int k = 0; k < n; k++) begin
            if (model_tx.size() > 0) begin
               e = model_tx.pop_front();
            end else begin
               e = 8'hFF;
               exp_und++;
            end
            exp_bus.push_back({1'b1, e});
            read_byte(d, k == n - 1);
            obs_bus.push_back({1'b1, d});
         end
      end
      i2c_stop();
      check("busy_stop_r", 32'(busy), 32'd0);
      chk_pulses();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       ack;
      logic [6:0] a;
      reset    = 1'b0;
      scl_m    = 1'b1;
      sda_m    = 1'b1;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tick(4);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_pulses", 32'({rx_overflow, tx_underflow}), 32'd0);
      reset = 1'b1;
      tick(4);

      wbuf[0] = 8'hA5;
      wbuf[1] = 8'h3C;
      do_write(OWN, 2, 1'b1);
      check("rx_held", 32'(rx_valid), 32'd1);
      drain();

      wbuf[0] = 8'h12;
      wbuf[1] = 8'h34;
      oe_cycles = 0;
      count_oe  = 1'b1;
      do_write(7'h28, 2, 1'b1);
      count_oe = 1'b0;
      check("foreign_oe", 32'(oe_cycles), 32'd0);
      check("foreign_rx", 32'(rx_valid), 32'd0);

      tx_push(8'h11);
      tx_push(8'h22);
      do_read(OWN, 2);

      do_read(OWN, 2);

      rx_ready = 1'b0;
      for (int k = 0; k < 5; k++) wbuf[k] = 8'($urandom);
      do_write(OWN, 5, 1'b1);
      drain();

      rx_ready = 1'b0;
      tx_push(8'h5A);
      wbuf[0] = 8'h01;
      do_write(OWN, 1, 1'b0);
      do_read(OWN, 2);
      check("rx_after_sr", 32'(rx_valid), 32'd1);
      drain();

      tx_push(8'h00);
      i2c_start();
      exp_bus.push_back({1'b0, 7'd0, 1'b0});
      write_byte({OWN, 1'b1}, ack);
      obs_bus.push_back({1'b0, 7'd0, ack});
      check("oe_mid_byte", 32'(sda_oe), 32'd1);
      reset = 1'b0;
      #1;
      check("oe_after_reset", 32'(sda_oe), 32'd0);
      check("busy_after_reset", 32'(busy), 32'd0);
      model_tx.delete();
      exp_rx.delete();
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(4);
      reset = 1'b1;
      tick(4);
      check("tx_empty_reset", 32'(tx_ready), 32'd1);
      check("rx_empty_reset", 32'(rx_valid), 32'd0);

      for (int it = 0; it < 14; it++) begin
         for (int j = 0; j < int'($urandom_range(0, 3)); j++)
            tx_push(8'($urandom));
         a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : OWN;
         rx_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
            do_write(a, int'($urandom_range(1, 6)), 1'b1);
         end else begin
            do_read(a, int'($urandom_range(1, 5)));
         end
         drain();
      end

      tick(4);
      check("bus_pending", 32'(exp_bus.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
